alu_sequencer: RTL and testbench

Multi-cycle controller that owns the shared combinational ALU. It accepts one operation request at a time over a valid/ready handshake and evaluates a 4-bit ARM-style condition against its architectural NZCV flag register. It then drives the ALU for a programmable number of cycles, captures the result, optionally updates the flags, and returns the result over a valid/ready response channel. It sits between instruction decode and register-file writeback.

---
 rtl/alu_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_alu_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Multi-cycle ALU controller: accepts one request at a time, checks an ARM-style condition
// against the NZCV register, drives the shared ALU for a fixed cycle count and returns the result.
module alu_sequencer #(
   parameter int unsigned EXEC_CYCLES = 1,
   parameter int unsigned MUL_CYCLES  = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [3:0]  req_op,
   input  logic [3:0]  req_cond,
   input  logic        req_setf,
   input  logic [31:0] req_src1,
   input  logic [31:0] req_src2,
   output logic [31:0] alu_src1,
   output logic [31:0] alu_src2,
   output logic [3:0]  alu_ctrl,
   output logic        alu_carr,
   input  logic [31:0] alu_result,
   input  logic [3:0]  alu_nzvc,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_result,
   output logic        resp_skipped,
   output logic        resp_illegal,
   output logic [3:0]  flags,
   input  logic        flags_wr_en,
   input  logic [3:0]  flags_wr_data
);

   typedef enum logic [1:0] {StIdle, StEval, StExec, StResp} state_e;

   localparam logic [3:0] OpMult = 4'd6;
   localparam logic [3:0] OpRrx  = 4'd12;
   localparam logic [3:0] OpMove = 4'd13;

   localparam logic [3:0] MulLoad  = 4'(MUL_CYCLES - 1);
   localparam logic [3:0] ExecLoad = 4'(EXEC_CYCLES - 1);

   state_e      state;
   logic [3:0]  op_q;
   logic [3:0]  cond_q;
   logic        setf_q;
   logic [31:0] src1_q;
   logic [31:0] src2_q;
   logic [3:0]  cnt;

   logic        cond_pass;
   logic        op_illegal;
   logic        op_arith;
   logic        flag_n;
   logic        flag_z;
   logic        flag_v;
   logic        flag_c;

   // Flag register layout is {N, Z, V, C}; carry lives in bit 0.
   assign flag_n = flags[3];
   assign flag_z = flags[2];
   assign flag_v = flags[1];
   assign flag_c = flags[0];

   assign alu_carr   = flags[0];
   assign op_illegal = (op_q[3:1] == 3'b111);
   assign op_arith   = (op_q <= OpMult) || (op_q == OpRrx);

   always_comb begin
      cond_pass = 1'b0;
      unique case (cond_q)
         4'd0:    cond_pass = flag_z;
         4'd1:    cond_pass = !flag_z;
         4'd2:    cond_pass = flag_c;
         4'd3:    cond_pass = !flag_c;
         4'd4:    cond_pass = flag_n;
         4'd5:    cond_pass = !flag_n;
         4'd6:    cond_pass = flag_v;
         4'd7:    cond_pass = !flag_v;
         4'd8:    cond_pass = flag_c && !flag_z;
         4'd9:    cond_pass = !flag_c || flag_z;
         4'd10:   cond_pass = (flag_n == flag_v);
         4'd11:   cond_pass = (flag_n != flag_v);
         4'd12:   cond_pass = !flag_z && (flag_n == flag_v);
         4'd13:   cond_pass = flag_z || (flag_n != flag_v);
         4'd14:   cond_pass = 1'b1;
         default: cond_pass = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= StIdle;
         op_q         <= OpMove;
         cond_q       <= 4'd0;
         setf_q       <= 1'b0;
         src1_q       <= 32'd0;
         src2_q       <= 32'd0;
         cnt          <= 4'd0;
         flags        <= 4'd0;
         req_ready    <= 1'b1;
         resp_valid   <= 1'b0;
         resp_result  <= 32'd0;
         resp_skipped <= 1'b0;
         resp_illegal <= 1'b0;
         alu_src1     <= 32'd0;
         alu_src2     <= 32'd0;
         alu_ctrl     <= OpMove;
      end else begin
         // External load first so a same-cycle ALU flag update below takes priority.
         if (flags_wr_en) begin
            flags <= flags_wr_data;
         end

         unique case (state)
            StIdle: begin
               if (req_valid) begin
                  op_q      <= req_op;
                  cond_q    <= req_cond;
                  setf_q    <= req_setf;
                  src1_q    <= req_src1;
                  src2_q    <= req_src2;
                  req_ready <= 1'b0;
                  state     <= StEval;
               end
            end

            StEval: begin
               if (op_illegal) begin
                  resp_result  <= 32'd0;
                  resp_skipped <= 1'b0;
                  resp_illegal <= 1'b1;
                  resp_valid   <= 1'b1;
                  state        <= StResp;
               end else if (!cond_pass) begin
                  resp_result  <= 32'd0;
                  resp_skipped <= 1'b1;
                  resp_illegal <= 1'b0;
                  resp_valid   <= 1'b1;
                  state        <= StResp;
               end else begin
                  cnt      <= (op_q == OpMult) ? MulLoad : ExecLoad;
                  alu_src1 <= src1_q;
                  alu_src2 <= src2_q;
                  alu_ctrl <= op_q;
                  state    <= StExec;
               end
            end

            StExec: begin
               if (cnt == 4'd0) begin
                  resp_result  <= alu_result;
                  resp_skipped <= 1'b0;
                  resp_illegal <= 1'b0;
                  resp_valid   <= 1'b1;
                  state        <= StResp;
                  if (setf_q) begin
                     if (op_arith) begin
                        flags <= alu_nzvc;
                     end else begin
                        flags <= {alu_nzvc[3:2], flags[1], alu_nzvc[0]};
                     end
                  end
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end

            StResp: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  req_ready  <= 1'b1;
                  state      <= StIdle;
               end
            end

            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: scoreboard of expected responses, a programmable ALU stub,
// and immediate assertions at every comparison point.
module tb_alu_sequencer;

   localparam int unsigned ExecN = 1;
   localparam int unsigned MulN  = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [3:0]  req_op = 4'd0;
   logic [3:0]  req_cond = 4'd14;
   logic        req_setf = 1'b0;
   logic [31:0] req_src1 = 32'd0;
   logic [31:0] req_src2 = 32'd0;
   logic [31:0] alu_src1;
   logic [31:0] alu_src2;
   logic [3:0]  alu_ctrl;
   logic        alu_carr;
   logic [31:0] alu_result;
   logic [3:0]  alu_nzvc;
   logic        resp_valid;
   logic        resp_ready = 1'b1;
   logic [31:0] resp_result;
   logic        resp_skipped;
   logic        resp_illegal;
   logic [3:0]  flags;
   logic        flags_wr_en = 1'b0;
   logic [3:0]  flags_wr_data = 4'd0;

   logic [31:0] model_result = 32'd0;
   logic [3:0]  model_nzvc = 4'd0;

   typedef struct {
      logic [31:0] result;
      logic        skipped;
      logic        illegal;
      logic [3:0]  flags;
      int          lat;
   } exp_t;

   exp_t sb[$];

   int         passed = 0;
   int         total = 0;
   logic [3:0] exp_flags = 4'd0;
   logic [3:0] exp_ctrl = 4'd13;

   alu_sequencer #(
      .EXEC_CYCLES(ExecN),
      .MUL_CYCLES (MulN)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_op       (req_op),
      .req_cond     (req_cond),
      .req_setf     (req_setf),
      .req_src1     (req_src1),
      .req_src2     (req_src2),
      .alu_src1     (alu_src1),
      .alu_src2     (alu_src2),
      .alu_ctrl     (alu_ctrl),
      .alu_carr     (alu_carr),
      .alu_result   (alu_result),
      .alu_nzvc     (alu_nzvc),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_result  (resp_result),
      .resp_skipped (resp_skipped),
      .resp_illegal (resp_illegal),
      .flags        (flags),
      .flags_wr_en  (flags_wr_en),
      .flags_wr_data(flags_wr_data)
   );

   always #5 clk = ~clk;

   assign alu_result = model_result;
   assign alu_nzvc   = model_nzvc;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   // Reference condition table; flags are {N, Z, V, C}.
   function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
      logic n, z, v, cy;
      n = f[3];
      z = f[2];
      v = f[1];
      cy = f[0];
      case (c)
         4'd0:    return z;
         4'd1:    return !z;
         4'd2:    return cy;
         4'd3:    return !cy;
         4'd4:    return n;
         4'd5:    return !n;
         4'd6:    return v;
         4'd7:    return !v;
         4'd8:    return cy && !z;
         4'd9:    return !cy || z;
         4'd10:   return n == v;
         4'd11:   return n != v;
         4'd12:   return !z && (n == v);
         4'd13:   return z || (n != v);
         4'd14:   return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   task automatic set_flags(input logic [3:0] v);
      flags_wr_en   = 1'b1;
      flags_wr_data = v;
      @(posedge clk);
      #1;
      flags_wr_en = 1'b0;
      exp_flags   = v;
      chk("set_flags", 32'(flags), 32'(v));
   endtask

   // Called #1 after a posedge; returns #1 after the posedge following the response.
   task automatic do_req(input string tag, input logic [3:0] op, input logic [3:0] cond,
                         input logic setf, input logic [31:0] s1, input logic [31:0] s2,
                         input logic [31:0] res, input logic [3:0] nzvc, input logic collide);
      exp_t e;
      exp_t g;
      logic run;
      logic arith;
      logic got;
      int   n;
      int   edges;
      run   = (op < 4'd14) && cond_ok(cond, exp_flags);
      arith = (op <= 4'd6) || (op == 4'd12);
      n     = (op == 4'd6) ? int'(MulN) : int'(ExecN);
      e.illegal = (op >= 4'd14);
      e.skipped = !e.illegal && !run;
      e.result  = run ? res : 32'd0;
      e.lat     = run ? 2 + n : 2;
      if (run && setf) begin
         exp_flags = arith ? nzvc : {nzvc[3:2], exp_flags[1], nzvc[0]};
      end
      e.flags = exp_flags;
      sb.push_back(e);

      model_result = res;
      model_nzvc   = nzvc;
      chk({tag, ".req_ready"}, 32'(req_ready), 32'd1);
      req_op    = op;
      req_cond  = cond;
      req_setf  = setf;
      req_src1  = s1;
      req_src2  = s2;
      req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      edges = 1;
      got   = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (resp_valid) begin
            got = 1'b1;
         end else begin
            if (run && edges >= 2) begin
               chk({tag, ".alu_ctrl"}, 32'(alu_ctrl), 32'(op));
               chk({tag, ".alu_src1"}, alu_src1, s1);
               chk({tag, ".alu_src2"}, alu_src2, s2);
            end
            if (collide && edges == 1 + n) begin
               flags_wr_en   = 1'b1;
               flags_wr_data = ~exp_flags;
            end
            @(posedge clk);
            #1;
            flags_wr_en = 1'b0;
            edges++;
         end
      end
      if (run) exp_ctrl = op;
      chk({tag, ".resp_seen"}, 32'(got), 32'd1);
      if (got && sb.size() > 0) begin
         g = sb.pop_front();
         chk({tag, ".latency"}, 32'(edges), 32'(g.lat));
         chk({tag, ".result"}, resp_result, g.result);
         chk({tag, ".skipped"}, 32'(resp_skipped), 32'(g.skipped));
         chk({tag, ".illegal"}, 32'(resp_illegal), 32'(g.illegal));
         chk({tag, ".flags"}, 32'(flags), 32'(g.flags));
         chk({tag, ".alu_carr"}, 32'(alu_carr), 32'(g.flags[0]));
         chk({tag, ".ctrl_last"}, 32'(alu_ctrl), 32'(exp_ctrl));
         chk({tag, ".req_ready_busy"}, 32'(req_ready), 32'd0);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst.req_ready", 32'(req_ready), 32'd1);
      chk("rst.resp_valid", 32'(resp_valid), 32'd0);
      chk("rst.flags", 32'(flags), 32'd0);
      chk("rst.alu_ctrl", 32'(alu_ctrl), 32'd13);
      chk("rst.alu_src1", alu_src1, 32'd0);
      chk("rst.resp_result", resp_result, 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      do_req("add", 4'd0, 4'd14, 1'b1, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 4'b1010, 1'b0);

      set_flags(4'b0100);
      do_req("skip_ne", 4'd13, 4'd1, 1'b1, 32'h1234, 32'd0, 32'h1234, 4'b1111, 1'b0);

      do_req("mult", 4'd6, 4'd14, 1'b1, 32'd6, 32'd7, 32'd42, 4'b0000, 1'b0);

      set_flags(4'b0010);
      do_req("and_keep_v", 4'd7, 4'd14, 1'b1, 32'hF0, 32'h0F, 32'd0, 4'b0101, 1'b0);

      do_req("xor_cs_nosetf", 4'd8, 4'd2, 1'b0, 32'hFF00, 32'h0FF0, 32'hF0F0, 4'b1000, 1'b0);
      do_req("minus_le", 4'd2, 4'd13, 1'b1, 32'd9, 32'd4, 32'd5, 4'b0010, 1'b0);
      do_req("hi_skip", 4'd0, 4'd8, 1'b1, 32'd1, 32'd1, 32'd2, 4'b0000, 1'b0);
      do_req("ge_skip", 4'd0, 4'd10, 1'b1, 32'd1, 32'd1, 32'd2, 4'b0000, 1'b0);
      do_req("lt_rrx", 4'd12, 4'd11, 1'b1, 32'h3, 32'd0, 32'h8000_0001, 4'b1001, 1'b0);
      do_req("nv_skip", 4'd13, 4'd15, 1'b1, 32'd7, 32'd0, 32'd7, 4'b0000, 1'b0);

      // Backpressure: response held while resp_ready is low
      resp_ready = 1'b0;
      do_req("or_bp", 4'd9, 4'd14, 1'b0, 32'hA000, 32'h0BCD, 32'hABCD, 4'b0000, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp.resp_valid", 32'(resp_valid), 32'd1);
         chk("bp.result", resp_result, 32'hABCD);
         chk("bp.skipped", 32'(resp_skipped), 32'd0);
         chk("bp.req_ready", 32'(req_ready), 32'd0);
         @(posedge clk);
         #1;
      end
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp.released_ready", 32'(req_ready), 32'd1);
      chk("bp.released_valid", 32'(resp_valid), 32'd0);
      do_req("after_bp", 4'd13, 4'd14, 1'b0, 32'h55, 32'd0, 32'h55, 4'b0000, 1'b0);

      // Reset in the middle of a MULT
      set_flags(4'b1111);
      req_op    = 4'd6;
      req_cond  = 4'd14;
      req_setf  = 1'b1;
      req_src1  = 32'd3;
      req_src2  = 32'd5;
      model_result = 32'd15;
      model_nzvc   = 4'b1010;
      req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("midrst.exec_ctrl", 32'(alu_ctrl), 32'd6);
      rst_n = 1'b0;
      #1;
      chk("midrst.flags", 32'(flags), 32'd0);
      chk("midrst.resp_valid", 32'(resp_valid), 32'd0);
      chk("midrst.req_ready", 32'(req_ready), 32'd1);
      chk("midrst.alu_ctrl", 32'(alu_ctrl), 32'd13);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      exp_flags = 4'd0;
      exp_ctrl  = 4'd13;
      repeat (5) @(posedge clk);
      #1;
      chk("midrst.no_resp", 32'(resp_valid), 32'd0);
      chk("midrst.flags_after", 32'(flags), 32'd0);

      set_flags(4'b1001);
      do_req("illegal15", 4'd15, 4'd14, 1'b1, 32'd1, 32'd2, 32'hDEAD, 4'b0110, 1'b0);
      do_req("illegal14", 4'd14, 4'd15, 1'b1, 32'd1, 32'd2, 32'hBEEF, 4'b0110, 1'b0);

      // External flag write collides with the final EXEC cycle; ALU update wins
      do_req("collide_add", 4'd0, 4'd14, 1'b1, 32'd1, 32'd2, 32'd3, 4'b0001, 1'b1);
      do_req("collide_mult", 4'd6, 4'd14, 1'b1, 32'd2, 32'd2, 32'd4, 4'b0110, 1'b1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
